// File: rtl/bpsk_pkg.sv
// rtl/bpsk_pkg.sv - shared BPSK constants for modulator and demodulator
package bpsk_pkg;

  localparam int SINE_WIDTH         = 12;
  localparam int DATA_WIDTH         = 8;
  localparam int SAMPLES_PER_SYMBOL = 2**DATA_WIDTH;
  localparam int BITS_PER_WORD      = DATA_WIDTH + 1;
  localparam int MIDSCALE           = 2**(SINE_WIDTH-1);
  localparam int ACC_WIDTH          = SINE_WIDTH + DATA_WIDTH + 1;

endpackage

// File: rtl/bpsk_correlator.sv
// rtl/bpsk_correlator.sv - half-period add/subtract correlator with symbol phase counter
module bpsk_correlator
  import bpsk_pkg::*;
(
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  en,
  input  logic [SINE_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  output logic                  symbol_done,
  output logic                  bit_dec
);

  logic [DATA_WIDTH-1:0]       phase_cnt;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic signed [SINE_WIDTH:0]  s;
  logic signed [ACC_WIDTH-1:0] s_ext;
  logic                        accept;

  assign accept = en & sample_valid;
  assign s      = $signed({1'b0, sample_in}) - $signed((SINE_WIDTH+1)'(MIDSCALE));
  assign s_ext  = {{(ACC_WIDTH-SINE_WIDTH-1){s[SINE_WIDTH]}}, s};

  always_comb begin
    acc_next = acc + s_ext;
    if (phase_cnt[DATA_WIDTH-1]) acc_next = acc - s_ext;
  end

  // A zero correlation (tie) decides 0.
  assign bit_dec     = !acc_next[ACC_WIDTH-1] && (acc_next != '0);
  assign symbol_done = accept && (phase_cnt == '1);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      phase_cnt <= '0;
      acc       <= '0;
    end else if (!en) begin
      phase_cnt <= '0;
      acc       <= '0;
    end else if (sample_valid) begin
      phase_cnt <= phase_cnt + DATA_WIDTH'(1);
      acc       <= (phase_cnt == '1) ? '0 : acc_next;
    end
  end

endmodule

// File: rtl/bpsk_demodulator.sv
// rtl/bpsk_demodulator.sv - BPSK receiver: bit decisions reassembled LSB first into words
module bpsk_demodulator
  import bpsk_pkg::*;
(
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  en,
  input  logic [SINE_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  output logic                  bit_out,
  output logic                  bit_valid,
  output logic [DATA_WIDTH:0]   data_out,
  output logic                  data_valid
);

  localparam int BIT_CNT_W = $clog2(BITS_PER_WORD);

  logic                     symbol_done;
  logic                     bit_dec;
  logic [BIT_CNT_W-1:0]     bit_cnt;
  logic [DATA_WIDTH:0]      shreg;
  logic [DATA_WIDTH:0]      word_next;

  bpsk_correlator u_corr (
    .clk          (clk),
    .arst_n       (arst_n),
    .en           (en),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .symbol_done  (symbol_done),
    .bit_dec      (bit_dec)
  );

  always_comb begin
    word_next = shreg;
    for (int i = 0; i < BITS_PER_WORD; i++) begin
      if (bit_cnt == BIT_CNT_W'(i)) word_next[i] = bit_dec;
    end
  end

  // bit_out/data_out hold across en=0; only progress state and valids clear.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      bit_out    <= 1'b0;
      bit_valid  <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else if (!en) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      bit_valid  <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      bit_valid  <= 1'b0;
      data_valid <= 1'b0;
      if (symbol_done) begin
        bit_out   <= bit_dec;
        bit_valid <= 1'b1;
        if (bit_cnt == BIT_CNT_W'(DATA_WIDTH)) begin
          data_out   <= word_next;
          data_valid <= 1'b1;
          bit_cnt    <= '0;
          shreg      <= '0;
        end else begin
          shreg   <= word_next;
          bit_cnt <= bit_cnt + BIT_CNT_W'(1);
        end
      end
    end
  end

endmodule
